// File: rtl/fifo_burst_reader.sv
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Burst read master for the synchronous fifo block; pops N words
//                and streams them on a valid/ready port through a 2-entry skid.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             fifo_pop,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_inflight;
    logic               r_inflight_last;
    logic [WIDTH-1:0]   r_buf_data [2];
    logic [1:0]         r_buf_last;
    logic [1:0]         r_count;

    logic               w_out_hs;
    logic [1:0]         w_occ;
    logic [1:0]         w_occ_net;
    logic               w_pop;
    logic               w_wr_idx;
    logic [1:0]         w_wr_pos;

    assign m_valid   = (r_count != 2'd0);
    assign m_data    = r_buf_data[0];
    assign m_last    = m_valid && r_buf_last[0];
    assign w_out_hs  = m_valid && m_ready;

    // Occupancy counts the word still in flight from the FIFO, so a pop is
    // only issued when its data is guaranteed a free skid slot on arrival.
    assign w_occ     = r_count + {1'b0, r_inflight};
    assign w_occ_net = w_occ - {1'b0, w_out_hs};
    assign w_pop     = (r_state == ST_READ) && (r_remaining != '0)
                       && !fifo_empty && (w_occ_net < 2'd2);

    // Arriving word lands behind whatever survives this cycle's output handshake.
    assign w_wr_pos  = r_count - {1'b0, w_out_hs};
    assign w_wr_idx  = w_wr_pos[0];

    assign fifo_pop  = w_pop;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_next = (cmd_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (r_remaining == '0) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_hs && m_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_count         <= 2'd0;
            r_buf_last      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;

            if ((r_state == ST_IDLE) && cmd_valid) begin
                r_remaining <= cmd_len;
            end else if (w_pop) begin
                r_remaining <= r_remaining - c_LEN_ONE;
            end

            r_inflight      <= w_pop;
            r_inflight_last <= w_pop && (r_remaining == c_LEN_ONE);
            r_count         <= r_count - {1'b0, w_out_hs} + {1'b0, r_inflight};

            if (w_out_hs) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_last[0] <= r_buf_last[1];
            end
            // Later assignment wins when the arrival targets the head slot.
            if (r_inflight) begin
                r_buf_data[w_wr_idx] <= fifo_dout;
                r_buf_last[w_wr_idx] <= r_inflight_last;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Self-checking bench for fifo_burst_reader with a FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .fifo_pop(fifo_pop), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    // Behavioural FIFO: registered dout on pop, pushes become visible at the next edge
    logic [7:0] fq[$];
    logic [7:0] pend[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            fq.delete();
            pend.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_pop && fq.size() != 0) fifo_dout <= fq.pop_front();
            while (pend.size() != 0) fq.push_back(pend.pop_front());
            fifo_empty <= (fq.size() == 0);
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        int         stall;
        int         gap;
        int         exp_beats;
        int         exp_done;
    } vec_t;

    beat_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard compare, hold-stability and pop-legality checks
    int    ncyc = 0, beats = 0, pops = 0, done_cnt = 0;
    int    first_hs = -1, last_hs = -1, done_at = -1;
    logic  prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic  prev_l = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        ncyc++;
        if (rst_n) begin
            if (fifo_empty) check("pop_while_empty", 32'(fifo_pop), 0);
            if (fifo_pop) pops++;
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(prev_d));
                check("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (m_valid && m_ready) begin
                check("beat_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat_data", 32'(m_data), 32'(e.d));
                    check("beat_last", 32'(m_last), 32'(e.l));
                end
                beats++;
                if (first_hs < 0) first_hs = ncyc;
                last_hs = ncyc;
            end
            if (done) begin
                done_cnt++;
                done_at = ncyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_counters();
        beats = 0; pops = 0; done_cnt = 0;
        first_hs = -1; last_hs = -1; done_at = -1;
    endtask

    task automatic expect_burst(input logic [7:0] base, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = 8'(base + 8'(i));
            b.l = (i == len - 1);
            sb.push_back(b);
        end
    endtask

    // Entered at posedge+1; returns 1ns after the handshake edge with cmd_valid low
    task automatic send_cmd(input int len);
        logic ok_r;
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        for (int k = 0; k < 50; k++) begin
            ok_r = cmd_ready;
            @(posedge clk);
            if (ok_r) begin
                ok = 1'b1;
                break;
            end
            #1;
        end
        check("cmd_accept", 32'(ok), 1);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) break;
        end
        check("burst_done_seen", 32'(done_cnt >= target), 1);
    endtask

    task automatic run_vec(input vec_t v);
        clear_counters();
        m_ready = (v.stall == 0);
        if (v.gap == 0) begin
            for (int i = 0; i < v.len; i++) pend.push_back(8'(v.base + 8'(i)));
            repeat (2) @(posedge clk);
            #1;
        end
        expect_burst(v.base, v.len);
        send_cmd(v.len);
        if (v.len == 0) begin
            @(negedge clk); #1;
            check("zero_done", 32'(done), 1);
            @(negedge clk); #1;
            check("zero_done_once", 32'(done), 0);
            check("zero_cmd_ready", 32'(cmd_ready), 1);
        end else if (v.gap == 0) begin
            @(negedge clk); #1;
            check("lat_t0_valid", 32'(m_valid), 0);
            @(negedge clk); #1;
            check("lat_t1_valid", 32'(m_valid), 0);
            @(negedge clk); #1;
            check("lat_t2_valid", 32'(m_valid), 1);
            check("first_data", 32'(m_data), 32'(v.base));
            if (v.stall > 0) begin
                for (int s = 1; s < v.stall; s++) begin
                    @(negedge clk); #1;
                    check("stall_valid", 32'(m_valid), 1);
                    check("stall_data", 32'(m_data), 32'(v.base));
                end
                check("stall_fifo_drop", 32'(fq.size() >= v.len - 2), 1);
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        end else begin
            for (int i = 0; i < v.len; i++) begin
                repeat (v.gap) @(posedge clk);
                #1 pend.push_back(8'(v.base + 8'(i)));
            end
        end
        wait_done(v.exp_done);
        repeat (2) @(negedge clk);
        #1;
        check("done_count", done_cnt, v.exp_done);
        check("beat_count", beats, v.exp_beats);
        check("pop_count", pops, v.len);
        check("sb_drained", sb.size(), 0);
        check("end_busy", 32'(busy), 0);
        check("end_cmd_ready", 32'(cmd_ready), 1);
        check("end_fifo_empty", 32'(fifo_empty), 1);
        check("end_m_valid", 32'(m_valid), 0);
        if (v.gap == 0 && v.stall == 0 && v.len > 0) begin
            check("consecutive_beats", last_hs - first_hs, v.len - 1);
            check("done_after_last", done_at, last_hs + 1);
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[4];
    vec_t v2;
    logic accepted2;

    initial begin
        vecs[0] = '{len: 4, base: 8'h00, stall: 0, gap: 0, exp_beats: 4, exp_done: 1};
        vecs[1] = '{len: 8, base: 8'h10, stall: 5, gap: 0, exp_beats: 8, exp_done: 1};
        vecs[2] = '{len: 3, base: 8'hA1, stall: 0, gap: 3, exp_beats: 3, exp_done: 1};
        vecs[3] = '{len: 0, base: 8'h00, stall: 0, gap: 0, exp_beats: 0, exp_done: 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_fifo_pop", 32'(fifo_pop), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset in the middle of a burst
        clear_counters();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) pend.push_back(8'(8'h20 + 8'(i)));
        repeat (2) @(posedge clk);
        #1;
        expect_burst(8'h20, 6);
        send_cmd(6);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (beats >= 2) break;
        end
        check("mid_reset_two_beats", 32'(beats >= 2), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk); #1;
        check("post_rst_m_valid", 32'(m_valid), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_no_done", done_cnt, 0);
        @(posedge clk); #1;
        v2 = '{len: 2, base: 8'h30, stall: 0, gap: 0, exp_beats: 2, exp_done: 1};
        run_vec(v2);

        // Back-to-back commands with the second held valid while busy
        clear_counters();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) pend.push_back(8'(8'h40 + 8'(i)));
        repeat (2) @(posedge clk);
        #1;
        expect_burst(8'h40, 2);
        expect_burst(8'h42, 3);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(2);
        @(posedge clk); #1;
        cmd_len   = LEN_W'(3);
        accepted2 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (busy) check("b2b_cmd_ready_low", 32'(cmd_ready), 0);
            if (cmd_valid && cmd_ready && !accepted2) begin
                check("b2b_first_done_before_accept", done_cnt, 1);
                accepted2 = 1'b1;
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
            if (done_cnt >= 2) break;
        end
        check("b2b_second_accepted", 32'(accepted2), 1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("b2b_done_count", done_cnt, 2);
        check("b2b_beat_count", beats, 5);
        check("b2b_sb_drained", sb.size(), 0);
        check("b2b_end_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the synchronous `fifo` block (push/pop, registered dout, full/empty flags).
- On a burst command of N words, it pops N words from the FIFO's read port as they become available.
- It presents those words on a valid/ready output stream, flagging the final word with m_last.
- An internal 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so it sustains one word per cycle under full throughput and honours backpressure without losing data.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- LEN_W, 8, width of burst length field; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  reader can accept a command; high only in IDLE
- cmd_len  in  LEN_W  number of words to read; sampled on command handshake
- fifo_pop  out  1  pop request to FIFO read port
- fifo_dout  in  WIDTH  FIFO read data; updated at the edge where a pop is accepted
- fifo_empty  in  1  FIFO empty flag
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  WIDTH  output word
- m_last  out  1  final word of the current burst
- busy  out  1  a burst is in progress (state != IDLE)
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; skid buffer and in-flight flag cleared; remaining=0.
  - Outputs: cmd_ready=1, fifo_pop=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
- States: IDLE, READ, DRAIN, DONE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch remaining=cmd_len. If cmd_len==0 go to DONE, otherwise go to READ.
  - READ: issue pops until remaining==0, then go to DRAIN. remaining decrements on each issued pop.
  - DRAIN: no pops. Go to DONE on the edge where the m_last word handshakes (m_valid&&m_ready&&m_last).
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Pop rule (combinational):
  - fifo_pop = (state==READ) && remaining!=0 && !fifo_empty && (occ - out_hs) < 2.
  - occ = skid entries + in-flight word (0..2); out_hs = m_valid&&m_ready.
  - fifo_pop is never asserted when fifo_empty=1, so every issued pop is accepted.
- Read latency:
  - A pop issued in cycle C sets in_flight.
  - fifo_dout is captured into the skid buffer at edge C+1.
  - m_valid is asserted from edge C+1 onward.
  - Command handshake edge T: first pop at T+1 (FIFO non-empty), first m_valid after edge T+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle is sustained.
- Skid buffer:
  - 2-entry in-order buffer; m_data and m_last come from the head entry.
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable and m_valid stays 1.
  - The buffer never overflows, guaranteed by the occ rule.
- m_last: set on the entry whose pop made remaining go 1->0.
- Empty FIFO mid-burst: pops stall; m_valid drops once the buffer is empty; the burst resumes when fifo_empty falls. There is no timeout.
- cmd_valid outside IDLE is ignored (cmd_ready=0); the command is not lost as long as the requester holds it.
- Reset mid-burst:
  - All state is abandoned at the reset edge, including an in-flight word; no done pulse is generated.
  - The FIFO is reset separately by its own rst_n.
- Widths: remaining is LEN_W bits and never underflows, since decrements happen only when remaining!=0.

Test Plan:
1. Burst with free-running output: preload FIFO 00,01,02,03, cmd_len=4, m_ready=1.
   - Beats 00,01,02,03 on 4 consecutive cycles, first m_valid after edge T+2.
   - m_last only on 03; done pulse 1 cycle after the 03 handshake; FIFO empty; busy=0.
2. Backpressure: preload 10..17, cmd_len=8, m_ready low for 5 cycles after the first beat.
   - m_valid stays 1 and m_data holds 10.
   - FIFO count drops by at most 2 during the stall.
   - After release, 10..17 arrive in order with no loss or duplication.
3. Empty-FIFO stall: FIFO empty, cmd_len=3; push A1,A2,A3 spaced 3 cycles apart.
   - fifo_pop never asserted while fifo_empty=1.
   - Beats A1,A2,A3 in order; m_last on A3.
4. Zero length: cmd_len=0.
   - No fifo_pop, no m_valid; done high for 1 cycle after the command edge; cmd_ready returns to 1.
5. Reset mid-burst: cmd_len=6 over words 20..25; assert rst_n=0 for 2 cycles after 2 beats.
   - After release: m_valid=0, busy=0, cmd_ready=1, done never pulsed.
   - Reset and refill the FIFO with 30,31; a new cmd_len=2 yields 30,31 with m_last on 31.
6. Back-to-back commands: preload 40..44; cmd_len=2, then cmd_len=3 held valid.
   - Second command accepted only after DONE; cmd_ready=0 throughout busy.
   - m_last on 41 and 44; exactly 2 done pulses.
